pc_sequencer: RTL

//  Parametrised program-counter unit for the 16-bit core: owns the PC register and computes next PC

---
 rtl/pc_sequencer.sv | 89 ++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter unit: owns the PC, selects increment / PC-relative / register-indirect next PC,
// holds on stall, parks in HALT on request and counts taken branches with saturation.
module pc_sequencer #(
  parameter int              PC_W     = 16,
  parameter int              IMM_W    = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    br_valid,
  input  logic                    br_reg,
  input  logic [2:0]              ccc,
  input  logic signed [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]         rs_val,
  input  logic [2:0]              flags,
  input  logic                    halt_req,
  output logic [PC_W-1:0]         pc_out,
  output logic [PC_W-1:0]         pc_plus,
  output logic                    taken,
  output logic                    halted,
  output logic [CNT_W-1:0]        taken_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  state_t                 state;
  logic                   cond_ok;
  logic signed [PC_W-1:0] imm_ext;
  logic [PC_W-1:0]        b_target;
  logic [PC_W-1:0]        br_target;
  logic [PC_W-1:0]        target;

  // flags are packed {Z,V,N}
  function automatic logic cond_eval(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'b000:  return !z;
      3'b001:  return z;
      3'b010:  return !z && !n;
      3'b011:  return n;
      3'b100:  return z || !n;
      3'b101:  return z || n;
      3'b110:  return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  assign cond_ok   = cond_eval(ccc, flags);
  assign pc_plus   = pc_out + PC_W'(2);
  assign imm_ext   = PC_W'(imm);
  // offset is in instruction words, so scale by two bytes before adding
  assign b_target  = pc_plus + {imm_ext[PC_W-2:0], 1'b0};
  assign br_target = {rs_val[PC_W-1:1], 1'b0};
  assign target    = br_reg ? br_target : b_target;
  assign taken     = br_valid && cond_ok && !stall && !halt_req && (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pc_out    <= RESET_PC;
      halted    <= 1'b0;
      taken_cnt <= '0;
    end else if (state == HALT) begin
      state  <= HALT;
      halted <= 1'b1;
    end else if (stall) begin
      state <= RUN;
    end else if (halt_req) begin
      // PC stays parked on the HLT instruction
      state  <= HALT;
      halted <= 1'b1;
    end else if (taken) begin
      pc_out    <= target;
      taken_cnt <= sat_inc(taken_cnt);
    end else begin
      pc_out <= pc_plus;
    end
  end

endmodule
